// File: rtl/jtopl_wrseq.sv
// jtopl_wrseq: queues host register writes in a small FIFO and plays each
// one out to the OPL core as an address strobe then a data strobe, with
// cen-timed waits after each strobe.
// Build option JTOPL_WRSEQ_SKIPADDR_EN: remember the last selected register
// and skip the address phase when the next entry targets the same register.
module jtopl_wrseq #(
  parameter int unsigned FIFO_AW   = 3,
  parameter int unsigned ADDR_WAIT = 3,
  parameter int unsigned DATA_WAIT = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cen,
  input  logic             i_req_valid,
  input  logic [7:0]       i_req_reg,
  input  logic [7:0]       i_req_val,
  output logic             o_req_ready,
  input  logic             i_flush,
  output logic [7:0]       o_opl_din,
  output logic             o_opl_addr,
  output logic             o_opl_write,
  output logic             o_busy,
  output logic [FIFO_AW:0] o_fifo_cnt
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;
  localparam int unsigned WMAX  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int unsigned WC_W  = (WMAX < 2) ? 1 : $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_AWAIT = 3'd2,
    S_DATA  = 3'd3,
    S_DWAIT = 3'd4
  } state_t;

  logic [15:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [CNT_W-1:0]   r_fifo_cnt;
  logic [CNT_W-1:0]   w_fifo_cnt_nxt;
  logic               r_req_ready;
  logic               w_push;
  logic               w_pop;
  logic [15:0]        w_head;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WC_W-1:0]    r_wcnt;
  logic [WC_W-1:0]    w_wcnt_nxt;
  logic [7:0]         r_hold_val;
  logic               r_opl_write;
  logic               r_opl_addr;
  logic [7:0]         r_opl_din;
  logic               r_busy;
  logic               w_write_nxt;
  logic               w_addr_nxt;
  logic [7:0]         w_din_nxt;

  // Flush takes priority over a push in the same cycle.
  assign w_push = i_req_valid && r_req_ready && !i_flush;
  assign w_head = r_mem[r_rptr];

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {i_req_reg, i_req_val};
  end

  // Wrap-around read/write pointers; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
    end
  end

  // Next occupancy from this cycle's push/pop/flush.
  always_comb begin
    w_fifo_cnt_nxt = r_fifo_cnt;
    if (i_flush)
      w_fifo_cnt_nxt = '0;
    else if (w_push && !w_pop)
      w_fifo_cnt_nxt = r_fifo_cnt + CNT_W'(1);
    else if (!w_push && w_pop)
      w_fifo_cnt_nxt = r_fifo_cnt - CNT_W'(1);
  end

  // Registered occupancy and ready, both derived from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_cnt  <= '0;
      r_req_ready <= 1'b1;
    end else begin
      r_fifo_cnt  <= w_fifo_cnt_nxt;
      r_req_ready <= (w_fifo_cnt_nxt != CNT_W'(DEPTH));
    end
  end

`ifdef JTOPL_WRSEQ_SKIPADDR_EN
  logic [7:0] r_shadow;
  logic       r_shadow_vld;
  logic       w_skip;

  assign w_skip = r_shadow_vld && (r_shadow == w_head[15:8]);

  // Track the register number last latched by an address phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
    end else if (w_pop && !w_skip) begin
      r_shadow     <= w_head[15:8];
      r_shadow_vld <= 1'b1;
    end
  end
`endif

  // Sequencer next state; strobes are launched on entry to ADDR/DATA so the
  // registered strobe lines up with the state that owns it.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_pop       = 1'b0;
    w_write_nxt = 1'b0;
    w_addr_nxt  = r_opl_addr;
    w_din_nxt   = r_opl_din;
    case (r_state)
      S_IDLE: begin
        if ((r_fifo_cnt != '0) && !i_flush) begin
          w_pop       = 1'b1;
          w_write_nxt = 1'b1;
`ifdef JTOPL_WRSEQ_SKIPADDR_EN
          if (w_skip) begin
            w_state_nxt = S_DATA;
            w_addr_nxt  = 1'b1;
            w_din_nxt   = w_head[7:0];
          end else begin
            w_state_nxt = S_ADDR;
            w_addr_nxt  = 1'b0;
            w_din_nxt   = w_head[15:8];
          end
`else
          w_state_nxt = S_ADDR;
          w_addr_nxt  = 1'b0;
          w_din_nxt   = w_head[15:8];
`endif
        end
      end
      S_ADDR: begin
        w_wcnt_nxt = WC_W'(ADDR_WAIT);
        if (ADDR_WAIT == 0) begin
          w_state_nxt = S_DATA;
          w_write_nxt = 1'b1;
          w_addr_nxt  = 1'b1;
          w_din_nxt   = r_hold_val;
        end else begin
          w_state_nxt = S_AWAIT;
        end
      end
      S_AWAIT: begin
        if (i_cen) begin
          if (r_wcnt <= WC_W'(1)) begin
            w_wcnt_nxt  = '0;
            w_state_nxt = S_DATA;
            w_write_nxt = 1'b1;
            w_addr_nxt  = 1'b1;
            w_din_nxt   = r_hold_val;
          end else begin
            w_wcnt_nxt = r_wcnt - WC_W'(1);
          end
        end
      end
      S_DATA: begin
        w_wcnt_nxt  = WC_W'(DATA_WAIT);
        w_state_nxt = (DATA_WAIT == 0) ? S_IDLE : S_DWAIT;
      end
      S_DWAIT: begin
        if (i_cen) begin
          if (r_wcnt <= WC_W'(1)) begin
            w_wcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_wcnt_nxt = r_wcnt - WC_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // Sequencer state, wait counter, holding register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_hold_val  <= '0;
      r_opl_write <= 1'b0;
      r_opl_addr  <= 1'b0;
      r_opl_din   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_opl_write <= w_write_nxt;
      r_opl_addr  <= w_addr_nxt;
      r_opl_din   <= w_din_nxt;
      r_busy      <= (w_state_nxt != S_IDLE) || (w_fifo_cnt_nxt != '0);
      if (w_pop) r_hold_val <= w_head[7:0];
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_fifo_cnt  = r_fifo_cnt;
  assign o_opl_write = r_opl_write;
  assign o_opl_addr  = r_opl_addr;
  assign o_opl_din   = r_opl_din;
  assign o_busy      = r_busy;

endmodule

// File: doc/jtopl_wrseq.md
JTOPL_WRSEQ -- requirements
Module: jtopl_wrseq

Interface
REQ-001 Parameter FIFO_AW, default 3, log2 of request FIFO depth (depth 8).
REQ-002 Parameter ADDR_WAIT, default 3, cen ticks of wait after an address write.
REQ-003 Parameter DATA_WAIT, default 23, cen ticks of wait after a data write.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cen  input  1  chip clock enable; all wait counters advance only on cen=1.
REQ-007 req_valid  input  1  host offers one register write.
REQ-008 req_reg  input  8  target register number.
REQ-009 req_val  input  8  value to write.
REQ-010 req_ready  output  1  FIFO not full; a push occurs when req_valid=1 and req_ready=1.
REQ-011 flush  input  1  discards all queued, not-yet-popped entries.
REQ-012 opl_din  output  8  data bus to the OPL register interface.
REQ-013 opl_addr  output  1  0 = address-select write, 1 = data write.
REQ-014 opl_write  output  1  write strobe, exactly one clk cycle wide.
REQ-015 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-016 fifo_cnt  output  FIFO_AW+1  current FIFO occupancy.

Function
REQ-017 The FIFO is a circular buffer of {reg,val} with wrap-around pointers; req_ready and fifo_cnt are registered and depend only on the count at the start of the cycle.
REQ-018 A pop in the same cycle as a push when full does not raise req_ready in that cycle; a simultaneous push and pop leaves fifo_cnt unchanged.
REQ-019 FSM states: IDLE, ADDR, AWAIT, DATA, DWAIT.
REQ-020 IDLE: if FIFO non-empty, pop one entry into a holding register and go to ADDR; a push at cycle t is popped no earlier than t+1.
REQ-021 ADDR: drive opl_write=1, opl_addr=0, opl_din=reg for one cycle; load counter with ADDR_WAIT; go to AWAIT.
REQ-022 AWAIT: decrement the counter on each cen; on the cen that reaches 0, go to DATA; ADDR_WAIT=0 goes straight to DATA.
REQ-023 DATA: drive opl_write=1, opl_addr=1, opl_din=val for one cycle; load counter with DATA_WAIT; go to DWAIT.
REQ-024 DWAIT: count as AWAIT; on expiry, go to IDLE.
REQ-025 Outside ADDR/DATA, opl_write=0; opl_din and opl_addr hold their last driven values.
REQ-026 flush zeroes the FIFO pointers and count next cycle; an in-flight transfer (ADDR..DWAIT) completes normally.
REQ-027 flush and push in the same cycle: flush wins and the push is dropped.
REQ-028 Entries are issued strictly in push order; no entry is duplicated or lost except by flush.

Reset
REQ-029 rst, including mid-transfer, forces next cycle: state IDLE, opl_write=0, opl_addr=0, opl_din=0, FIFO empty, fifo_cnt=0, req_ready=1, busy=0, counter=0, skip shadow invalid.

Configuration
REQ-030 Macro JTOPL_WRSEQ_SKIPADDR_EN: when defined, a shadow of the last address-phase register number and a valid bit are kept; if a popped reg equals the shadow and valid=1, IDLE goes directly to DATA, skipping ADDR/AWAIT.
REQ-031 Without JTOPL_WRSEQ_SKIPADDR_EN, every entry performs the full ADDR, AWAIT, DATA, DWAIT sequence; no shadow logic exists.

Verification
REQ-032 Push {0x02,0x55} at cycle 10 while idle, cen every cycle -> opl_write addr=0 din=0x02 at cycle 12; addr=1 din=0x55 at cycle 16; busy low at cycle 40.
REQ-033 Push 9 entries back-to-back with FIFO_AW=3 -> req_ready falls after the 8th push; all 9 entries issued in order; fifo_cnt never exceeds 8.
REQ-034 cen every 4th cycle, ADDR_WAIT=3 -> addr-to-data strobe spacing is exactly 3 cen ticks plus 1 clk.
REQ-035 Queue 4 entries, assert flush during first AWAIT -> first entry's data write still occurs; no further strobes; fifo_cnt=0.
REQ-036 rst pulse during DWAIT with 3 entries queued -> next cycle opl_write=0, busy=0, fifo_cnt=0; no strobes until a new push.
REQ-037 With JTOPL_WRSEQ_SKIPADDR_EN, push {0x04,0x80} then {0x04,0x01} -> second entry produces only the addr=1 strobe; without the macro it produces both strobes.
